// File: rtl/ann_pkg.sv
// Shared ANN datapath definitions: default widths, Q8.8 saturation limits and
// the neuron FSM encoding used by both the MAC unit and the layer sequencer.
package ann_pkg;

  localparam int ANN_DATA_W   = 16;
  localparam int ANN_FRAC_W   = 8;
  localparam int ANN_ADDR_W   = 5;
  localparam int ANN_N_INPUTS = 28;

  localparam int SAT_MAX = 32767;
  localparam int SAT_MIN = -32768;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    FINAL = 2'd3
  } state_t;

endpackage

// File: rtl/neuron_output_stage.sv
// Combinational accumulator-to-output conversion: Q8.8 rescale by arithmetic
// shift (rounds toward -inf), saturate to DATA_W, optional ReLU.
module neuron_output_stage
  import ann_pkg::*;
#(
  parameter int ACC_W    = 38,
  parameter int DATA_W   = ANN_DATA_W,
  parameter int FRAC_W   = ANN_FRAC_W,
  parameter bit ACT_RELU = 1'b1
) (
  input  logic signed [ACC_W-1:0]  acc,
  output logic        [DATA_W-1:0] y
);

  localparam logic signed [ACC_W-1:0] HI = ACC_W'(SAT_MAX);
  localparam logic signed [ACC_W-1:0] LO = ACC_W'(SAT_MIN);

  logic signed [ACC_W-1:0] s;

  always_comb begin
    s = acc >>> FRAC_W;
    if (s > HI)      y = HI[DATA_W-1:0];
    else if (s < LO) y = LO[DATA_W-1:0];
    else             y = s[DATA_W-1:0];
    if (ACT_RELU && y[DATA_W-1]) y = '0;
  end

endmodule

// File: rtl/neuron_mac_unit.sv
// Single-neuron MAC: sweeps weight/activation BRAMs over a shared address,
// accumulates W*X on top of the bias and emits one saturated output per START.
module neuron_mac_unit
  import ann_pkg::*;
#(
  parameter int N_INPUTS = ANN_N_INPUTS,
  parameter int ADDR_W   = ANN_ADDR_W,
  parameter int DATA_W   = ANN_DATA_W,
  parameter int FRAC_W   = ANN_FRAC_W,
  parameter int ACC_W    = 2*DATA_W+ADDR_W+1,
  parameter bit ACT_RELU = 1'b1
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              START,
  input  logic [DATA_W-1:0] BIAS,
  output logic [ADDR_W-1:0] ADDR,
  output logic              EN,
  output logic              WE,
  input  logic [DATA_W-1:0] W_DO,
  input  logic [DATA_W-1:0] X_DO,
  output logic [DATA_W-1:0] Y,
  output logic              BUSY,
  output logic              DONE
);

  localparam int STAGES = 1;

  state_t state, state_nx;

  logic [ADDR_W-1:0]         cnt;
  logic [STAGES:0]           vld_pipe;
  logic signed [2*DATA_W-1:0] w_ext, x_ext, prod;
  logic signed [ACC_W-1:0]   acc, bias_ext;
  logic [DATA_W-1:0]         y_nx;

  assign w_ext    = (2*DATA_W)'(signed'(W_DO));
  assign x_ext    = (2*DATA_W)'(signed'(X_DO));
  assign bias_ext = ACC_W'(signed'(BIAS));

  // vld_pipe[0]: an address is on the bus this cycle; [1]: prod holds its product
  assign vld_pipe[0] = (state == RUN);

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (START) state_nx = RUN;
      RUN:     if (cnt == ADDR_W'(N_INPUTS-1)) state_nx = DRAIN;
      DRAIN:   state_nx = FINAL;
      FINAL:   state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state              <= IDLE;
      cnt                <= '0;
      vld_pipe[STAGES:1] <= '0;
      prod               <= '0;
      acc                <= '0;
      Y                  <= '0;
      DONE               <= 1'b0;
    end else begin
      state       <= state_nx;
      vld_pipe[1] <= vld_pipe[0];
      prod        <= w_ext * x_ext;
      DONE        <= (state == FINAL);
      if (state == FINAL) Y <= y_nx;
      if (vld_pipe[1]) acc <= acc + ACC_W'(prod);
      // START only reaches here from IDLE, when the product pipe is empty
      if (state == IDLE && START) begin
        cnt <= '0;
        acc <= bias_ext <<< FRAC_W;
      end else if (state == RUN && state_nx == RUN) begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  neuron_output_stage #(
    .ACC_W    (ACC_W),
    .DATA_W   (DATA_W),
    .FRAC_W   (FRAC_W),
    .ACT_RELU (ACT_RELU)
  ) u_out (
    .acc (acc),
    .y   (y_nx)
  );

  assign ADDR = cnt;
  assign EN   = (state == RUN);
  assign WE   = 1'b0;
  assign BUSY = (state != IDLE);

endmodule
